// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: access FSM states,
// the EX/MEM register layout, MIPS opcodes used downstream and the link register.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } mem_state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic [5:0]  alu_op;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [31:0] pc_branch;
        logic [4:0]  wb_addr;
        logic [31:0] alu_out;
    } ex_mem_t;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [4:0] RA_ADDR = 5'd31;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-RAM access sequencer for the MEM stage: request/grant/response handshake,
// load-data capture and the stall/done decode seen by the pipeline.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              access,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              next_access,
    input  logic              next_misaligned,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] read_data
);

    mem_state_e state;
    mem_state_e state_next;

    // RAM-facing outputs decode state only, so mem_req drops with the async reset.
    assign mem_req = (state == REQ);
    assign mem_we  = mem_req & mem_write;
    assign done    = (state == DONE);
    assign stall   = valid & access & ~done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state is sequential, so it takes non-blocking assignments only.
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: the hold value is assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (!stall) begin
                    if (next_access) begin
                        state_next = next_misaligned ? DONE : REQ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            REQ:  if (mem_gnt)    state_next = RESP;
            RESP: if (mem_rvalid) state_next = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= '0;
        end else if ((state == RESP) && mem_rvalid && mem_to_reg) begin
            read_data <= mem_rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, branch/jump resolution and data-RAM access.
// Define MEM_STAGE_ALIGN_CHECK_EN to trap misaligned accesses via align_err.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic [5:0]        ALUopE,
    input  logic [31:0]       WriteData_in,
    input  logic [31:0]       PCPlus4_in,
    input  logic [31:0]       PCBranch_in,
    input  logic [4:0]        wb_addr_in,
    input  logic [31:0]       ALUOut_in,
    output logic              flush,
    output logic [31:0]       pc_target,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic [5:0]        ALUopM,
    output logic [31:0]       ALUOutM,
    output logic [31:0]       ReadDataM,
    output logic [31:0]       PCPlus4M,
    output logic [4:0]        wb_addr_M,
    output logic              align_err
);

    ex_mem_t           ex_mem;
    ex_mem_t           incoming;
    logic              valid;
    logic              access;
    logic              done;
    logic              next_access;
    logic              next_misaligned;
    logic [DATA_W-1:0] read_data;

    // A wrong-path instruction arriving while we redirect becomes a bubble.
    always_comb begin
        incoming = '{
            reg_write:  RegWriteE & ~flush,
            mem_to_reg: MemtoRegE & ~flush,
            mem_write:  MemWriteE & ~flush,
            branch:     BranchE   & ~flush,
            jump:       JumpE     & ~flush,
            alu_op:     ALUopE,
            write_data: WriteData_in,
            pc_plus4:   PCPlus4_in,
            pc_branch:  PCBranch_in,
            wb_addr:    wb_addr_in,
            alu_out:    ALUOut_in
        };
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_mem <= '0;
            valid  <= 1'b0;
        end else if (!stall) begin
            ex_mem <= incoming;
            valid  <= ~flush;
        end
    end

    assign access      = ex_mem.mem_to_reg | ex_mem.mem_write;
    assign next_access = incoming.mem_to_reg | incoming.mem_write;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign next_misaligned = (ALUOut_in[1:0] != 2'b00);
    assign align_err       = valid & access & done & (ex_mem.alu_out[1:0] != 2'b00);
`else
    assign next_misaligned = 1'b0;
    assign align_err       = 1'b0;
`endif

    mem_access_fsm #(
        .DATA_W(DATA_W)
    ) u_fsm (
        .clk             (CLK),
        .rst_n           (RST_N),
        .valid           (valid),
        .access          (access),
        .mem_write       (ex_mem.mem_write),
        .mem_to_reg      (ex_mem.mem_to_reg),
        .next_access     (next_access),
        .next_misaligned (next_misaligned),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .stall           (stall),
        .done            (done),
        .read_data       (read_data)
    );

    // Branches and jumps are never accesses, so flush cannot coincide with stall.
    assign flush     = valid & ((ex_mem.branch & (ex_mem.alu_out == 32'd1)) | ex_mem.jump);
    assign pc_target = ex_mem.jump ? ex_mem.alu_out : ex_mem.pc_branch;

    assign mem_addr  = ADDR_W'(ex_mem.alu_out & ~32'h3);
    assign mem_wdata = DATA_W'(ex_mem.write_data);

    assign wb_valid  = valid & (~access | done);
    assign RegWriteM = ex_mem.reg_write & wb_valid & ~align_err;
    assign MemtoRegM = ex_mem.mem_to_reg;
    assign ALUopM    = ex_mem.alu_op;
    assign ALUOutM   = ex_mem.alu_out;
    assign ReadDataM = 32'(read_data);
    assign PCPlus4M  = ex_mem.pc_plus4;
    assign wb_addr_M = ex_mem.wb_addr;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: instruction stream plus a RAM responder with
// random grant/response latencies, checked against a per-instruction timing model.
module tb_mem_stage;
    import mem_stage_pkg::*;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        CLK;
    logic        RST_N;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE;
    logic [5:0]  ALUopE;
    logic [31:0] WriteData_in, PCPlus4_in, PCBranch_in, ALUOut_in;
    logic [4:0]  wb_addr_in;
    logic        flush, stall, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] pc_target, mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid, RegWriteM, MemtoRegM, align_err;
    logic [5:0]  ALUopM;
    logic [31:0] ALUOutM, ReadDataM, PCPlus4M;
    logic [4:0]  wb_addr_M;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUopE(ALUopE),
        .WriteData_in(WriteData_in), .PCPlus4_in(PCPlus4_in),
        .PCBranch_in(PCBranch_in), .wb_addr_in(wb_addr_in), .ALUOut_in(ALUOut_in),
        .flush(flush), .pc_target(pc_target), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .ALUopM(ALUopM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .PCPlus4M(PCPlus4M), .wb_addr_M(wb_addr_M), .align_err(align_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw, m2r, mw, br, jmp;
        logic [5:0]  op;
        logic [31:0] wd, pc4, pcb, alu;
        logic [4:0]  wa;
        int          gw;     // REQ cycles before the one carrying mem_gnt
        int          rvw;    // RESP cycles before the one carrying mem_rvalid
        logic [31:0] rdata;
        bit          marker;
    } instr_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    instr_t      q[$];
    instr_t      cur, pending;
    bit          cur_valid;
    int          age;
    logic [31:0] exp_rd;
    int          n_captured;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic instr_t rand_instr(int kind);
        instr_t i;
        i.rw = 1'b0; i.m2r = 1'b0; i.mw = 1'b0; i.br = 1'b0; i.jmp = 1'b0;
        i.op = 6'($urandom()); i.wd = $urandom(); i.pc4 = $urandom();
        i.pcb = $urandom(); i.alu = $urandom(); i.wa = 5'($urandom());
        i.gw = $urandom_range(0, 3); i.rvw = $urandom_range(0, 3);
        i.rdata = $urandom(); i.marker = 1'b0;
        case (kind)
            0, 1: i.rw = 1'b1;
            2: begin
                i.rw = 1'b1; i.m2r = 1'b1; i.op = OP_LW;
                if ($urandom_range(0, 3) != 0) i.alu[1:0] = 2'b00;
            end
            3: begin
                i.mw = 1'b1; i.op = OP_SW;
                if ($urandom_range(0, 3) != 0) i.alu[1:0] = 2'b00;
            end
            4: begin i.br = 1'b1; i.op = OP_BEQ; i.alu = 32'($urandom_range(0, 1)); end
            5: begin i.br = 1'b1; i.op = OP_BNE; i.alu = 32'($urandom_range(0, 1)); end
            6: begin i.jmp = 1'b1; i.op = OP_J; end
            default: begin i.jmp = 1'b1; i.rw = 1'b1; i.op = OP_JAL; i.wa = RA_ADDR; end
        endcase
        return i;
    endfunction

    function automatic instr_t next_instr();
        if (q.size() > 0) return q.pop_front();
        return rand_instr($urandom_range(0, 7));
    endfunction

    task automatic drive_instr(input instr_t i);
        RegWriteE = i.rw; MemtoRegE = i.m2r; MemWriteE = i.mw;
        BranchE = i.br; JumpE = i.jmp; ALUopE = i.op;
        WriteData_in = i.wd; PCPlus4_in = i.pc4; PCBranch_in = i.pcb;
        wb_addr_in = i.wa; ALUOut_in = i.alu;
    endtask

    // Called at a falling edge: check this cycle, drive the next edge, advance the model.
    task automatic cycle();
        bit acc, mis, e_stall, e_req, e_wbv, e_flush, e_aerr, in_resp, rv_hit;
        int done_age, rv_age;
        acc      = cur_valid && (cur.m2r || cur.mw);
        mis      = acc && ALIGN_CHK && (cur.alu[1:0] != 2'b00);
        done_age = mis ? 0 : cur.gw + cur.rvw + 2;
        rv_age   = cur.gw + 1 + cur.rvw;
        e_stall  = acc && (age < done_age);
        e_req    = acc && !mis && (age <= cur.gw);
        in_resp  = acc && !mis && (age > cur.gw) && (age <= rv_age);
        rv_hit   = in_resp && (age == rv_age);
        e_wbv    = cur_valid && (!acc || age == done_age);
        e_aerr   = e_wbv && mis;
        e_flush  = cur_valid && ((cur.br && cur.alu == 32'd1) || cur.jmp);

        check("stall", 32'(stall), 32'(e_stall));
        check("wb_valid", 32'(wb_valid), 32'(e_wbv));
        check("flush", 32'(flush), 32'(e_flush));
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("mem_we", 32'(mem_we), 32'(e_req && cur.mw));
        check("align_err", 32'(align_err), 32'(e_aerr));
        check("RegWriteM", 32'(RegWriteM), 32'(e_wbv && cur.rw && !e_aerr));
        if (e_flush) check("pc_target", pc_target, cur.jmp ? cur.alu : cur.pcb);
        if (e_req) begin
            check("mem_addr", mem_addr, cur.alu & ~32'h3);
            check("mem_wdata", mem_wdata, cur.wd);
        end
        if (e_wbv) begin
            check("ALUOutM", ALUOutM, cur.alu);
            check("ALUopM", 32'(ALUopM), 32'(cur.op));
            check("PCPlus4M", PCPlus4M, cur.pc4);
            check("wb_addr_M", 32'(wb_addr_M), 32'(cur.wa));
            check("MemtoRegM", 32'(MemtoRegM), 32'(cur.m2r));
            if (cur.m2r && !mis) check("ReadDataM", ReadDataM, exp_rd);
        end

        drive_instr(pending);
        mem_gnt    = e_req   ? (age == cur.gw) : 1'($urandom_range(0, 1));
        mem_rvalid = in_resp ? rv_hit          : 1'($urandom_range(0, 1));
        mem_rdata  = rv_hit  ? cur.rdata       : $urandom();

        @(posedge CLK);
        if (rv_hit && cur.m2r) exp_rd = cur.rdata;
        if (!e_stall) begin
            cur       = pending;
            cur_valid = !e_flush;
            if (e_flush) begin
                cur.rw = 1'b0; cur.m2r = 1'b0; cur.mw = 1'b0;
                cur.br = 1'b0; cur.jmp = 1'b0; cur.marker = 1'b0;
            end
            age     = 0;
            pending = next_instr();
            n_captured++;
        end else begin
            age++;
        end
        @(negedge CLK);
    endtask

    initial begin
        instr_t d;
        bit found;
        int budget;

        RST_N = 1'b0;
        d = rand_instr(0);
        d.rw = 1'b0; d.op = '0; d.wd = '0; d.pc4 = '0; d.pcb = '0; d.wa = '0; d.alu = '0;
        drive_instr(d);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        cur = d; cur_valid = 1'b0; age = 0; exp_rd = '0; n_captured = 0;

        repeat (3) @(negedge CLK);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_pc_target", pc_target, 32'd0);
        check("rst_ReadDataM", ReadDataM, 32'd0);
        check("rst_ALUOutM", ALUOutM, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // Directed opening sequence, then random traffic.
        d = rand_instr(0); d.alu = 32'h15; d.wa = 5'd3; q.push_back(d);
        d = rand_instr(2); d.alu = 32'h40; d.gw = 0; d.rvw = 0; d.rdata = 32'hDEADBEEF; q.push_back(d);
        d = rand_instr(3); d.alu = 32'h80; d.wd = 32'h1234; d.gw = 2; d.rvw = 0; q.push_back(d);
        d = rand_instr(4); d.alu = 32'd1; d.pcb = 32'h100; q.push_back(d);
        d = rand_instr(0); q.push_back(d);
        d = rand_instr(6); d.alu = 32'h2000; q.push_back(d);
        d = rand_instr(0); q.push_back(d);
        d = rand_instr(5); d.alu = 32'd0; q.push_back(d);

        pending = next_instr();
        RST_N = 1'b1;
        budget = 0;
        while (n_captured < 400 && budget < 20000) begin
            cycle();
            budget++;
        end
        check("capture_progress", 32'(n_captured >= 400), 32'd1);

        // Abandon a load in RESP with an asynchronous reset.
        d = rand_instr(0); q.push_back(d);
        d = rand_instr(2); d.alu = 32'h300; d.gw = 0; d.rvw = 3; d.marker = 1'b1; q.push_back(d);
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (cur_valid && cur.marker && age == 2) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("reach_resp", 32'(found), 32'd1);
        if (found) begin
            check("pre_rst_stall", 32'(stall), 32'd1);
            RST_N = 1'b0;
            #1;
            check("mid_rst_mem_req", 32'(mem_req), 32'd0);
            check("mid_rst_stall", 32'(stall), 32'd0);
            check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
            check("mid_rst_RegWriteM", 32'(RegWriteM), 32'd0);
            check("mid_rst_ALUOutM", ALUOutM, 32'd0);
            check("mid_rst_mem_addr", mem_addr, 32'd0);
            @(negedge CLK);
            d = rand_instr(0);
            d.rw = 1'b0; d.op = '0; d.wd = '0; d.pc4 = '0; d.pcb = '0; d.wa = '0; d.alu = '0;
            drive_instr(d);
            mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
            RST_N = 1'b1;
            @(negedge CLK);
            check("post_rst_ReadDataM", ReadDataM, 32'd0);
            check("post_rst_stall", 32'(stall), 32'd0);
            check("post_rst_mem_req", 32'(mem_req), 32'd0);
            check("post_rst_wb_valid", 32'(wb_valid), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

MEM pipeline stage directly downstream of the EX stage. Holds the EX/MEM pipeline register and resolves branches and jumps, raising `flush` toward IF/ID/EX. Performs `lw`/`sw` accesses on a request/grant/response data-RAM port, stalling the pipeline until each access completes. Presents write-back operands to the WB stage with a valid strobe.

## Interface
Parameters:
- `ADDR_W`, 32: data-RAM address width.
- `DATA_W`, 32: data width.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: asynchronous active-low reset.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `BranchE`, `JumpE` in 1 each: EX control outputs.
- `ALUopE` in 6: opcode.
- `WriteData_in` in 32: store data.
- `PCPlus4_in` in 32: PC+4.
- `PCBranch_in` in 32: branch target.
- `wb_addr_in` in 5: destination register.
- `ALUOut_in` in 32: ALU result, address, branch flag or jump target.
- `flush` out 1: squash IF/ID/EX contents at the next edge.
- `pc_target` out 32: redirect PC, valid when `flush`=1.
- `stall` out 1: freeze IF/ID/EX and this stage's input register.
- `mem_req` out 1: data-RAM request.
- `mem_we` out 1: write request.
- `mem_addr` out ADDR_W: access address.
- `mem_wdata` out DATA_W: store data.
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1: response (load data or store ack).
- `mem_rdata` in DATA_W: load data.
- `wb_valid` out 1: instruction completes this cycle.
- `RegWriteM` out 1: write enable, already gated by `wb_valid`.
- `MemtoRegM` out 1.
- `ALUopM` out 6.
- `ALUOutM` out 32.
- `ReadDataM` out 32.
- `PCPlus4M` out 32.
- `wb_addr_M` out 5.
- `align_err` out 1: see Configuration.

## Operation
- EX/MEM register:
  - Captures all `*E`/`*_in` inputs at the rising edge when `stall`=0.
  - Holds its contents while `stall`=1.
  - If `flush`=1 at the capture edge, the incoming wrong-path instruction is turned into a bubble: all control bits are 0 and `valid`=0.
- Internal `valid` bit: 1 for every captured non-bubble instruction.
- Memory access: an instruction is an access if `MemtoRegM` or `MemWriteM` is set.
- Memory FSM, states IDLE, REQ, RESP, DONE:
  - IDLE→REQ: at the capture edge of an access.
  - REQ: `mem_req`=1, `mem_we`=`MemWriteM`, `mem_addr`=`ALUOutM`, `mem_wdata`=stored `WriteData`. Leaves for RESP on `mem_gnt`.
  - RESP: waits for `mem_rvalid`. Latches `mem_rdata` into `ReadDataM` on loads, then moves to DONE.
  - DONE: completes the access, then returns to IDLE, or to REQ if the next captured instruction is an access.
- `stall` = `valid` & access & state≠DONE.
- `wb_valid` = `valid` & (non-access | state==DONE).
- Branch resolution: `flush` = `valid` & ((`BranchM` & `ALUOutM`==1) | `JumpM`).
  - `pc_target` = `ALUOutM` when `JumpM`=1 (j/jr/jal), else `PCBranchM`.
  - Branches and jumps never stall, so `flush` lasts exactly one cycle.
- `mem_gnt` outside REQ and `mem_rvalid` outside RESP are ignored.
- `ALUopM`, `PCPlus4M` and `wb_addr_M` pass through from the register so WB can handle `jal` (op 000011, write to $31).

## Timing
- Reset values: all outputs 0, FSM in IDLE, register contents and `valid` 0, `ReadDataM` 0.
- Non-memory instruction: one cycle in MEM. `wb_valid`=1 in the cycle after capture.
- Access with `mem_gnt` in the first REQ cycle and `mem_rvalid` in the first RESP cycle: 3 cycles in MEM (REQ, RESP, DONE), `stall`=1 for 2 cycles.
  - Each extra wait cycle on `mem_gnt` or `mem_rvalid` adds one stall cycle.
- Outputs toward the RAM come straight from state and register, with no combinational path from `mem_gnt`/`mem_rvalid`.
- `flush` and `stall` are never both 1.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronously) and the access is abandoned. A response arriving after reset release is ignored.

## Configuration
- `MEM_STAGE_ALIGN_CHECK_EN` defined:
  - An access with `ALUOutM[1:0]`≠0 issues no request and goes IDLE→DONE.
  - In DONE it completes with `RegWriteM`=0 and `align_err`=1 for that one cycle.
- Undefined:
  - `mem_addr` = {`ALUOutM[31:2]`,2'b00}, so misaligned low bits are ignored.
  - `align_err` is tied to 0.

## Structure
- Package `mem_stage_pkg`:
  - FSM state enum.
  - Opcode constants `OP_LW`=100011, `OP_SW`=101011, `OP_BEQ`=000100, `OP_BNE`=000101, `OP_J`=000010, `OP_JAL`=000011.
  - `RA_ADDR`=5'd31.
- Sub-module `mem_access_fsm`: the state register, RAM handshake and the stall/done decode.
- The top level holds the EX/MEM register, branch resolution and output muxing.

## Test plan
- Reset release, then an `add` with ALUOut=0x15 and wb_addr=3 → one cycle later `wb_valid`=1, `RegWriteM`=1, `ALUOutM`=0x15, `stall`=0.
- `lw` at 0x40, `mem_gnt` in the same cycle, `mem_rvalid` with 0xDEADBEEF one cycle later → `stall`=1,1 then DONE with `ReadDataM`=0xDEADBEEF and `wb_valid`=1.
- `sw` at 0x80 with data 0x1234 and a 3-cycle `mem_gnt` delay → `mem_req`/`mem_we` held for 3 cycles with a stable address and data, total stall of 4 cycles.
- `beq` with ALUOut=1 and PCBranch=0x100, followed by an `addi` → `flush`=1 and `pc_target`=0x100 for one cycle; the `addi` is captured as a bubble with `wb_valid`=0 in the next cycle.
- `jr` with ALUOut=0x2000 → `flush`=1, `pc_target`=0x2000. `bne` with ALUOut=0 → `flush`=0.
- With `MEM_STAGE_ALIGN_CHECK_EN`, `lw` at 0x42 → no `mem_req`, `align_err`=1, `RegWriteM`=0. Separately, assert `RST_N` low during a `lw` in RESP → `mem_req`, `stall` and all outputs are 0 immediately.
